dsram_resp: RTL
===============

// Module: dsram_resp
// PURPOSE
//  Responder end of the EX-stage data SRAM port (data_sram_en/we/addr/wdata).
//  Holds a 64-bit-wide, byte-writable data memory. Services one load or store at a time.
//  Returns registered load data to the MEM stage.
//  Inserts programmable wait states and raises a stall request so the pipeline freezes while a slow access completes.
// PARAMETERS
//  ADDR_W     12           word-index width; depth = 2**ADDR_W 64-bit words
//  BASE_ADDR  64'h80000000 byte address of word 0
//  WAIT_CYC   0            extra wait states per access, 0..15
// PORTS
//  clk              in   1   clock (single clock domain)
//  rst              in   1   reset, synchronous, active-high
//  data_sram_en     in   1   access request from EX
//  data_sram_we     in   8   byte write enables; 0 = load, nonzero = store
//  data_sram_addr   in   64  byte address; bits [2:0] ignored (lanes chosen by we)
//  data_sram_wdata  in   64  store data, already lane-aligned by EX
//  data_sram_rdata  out  64  load data, registered
//  data_sram_rvalid out  1   one-cycle pulse: rdata updated by a completed load
//  stallreq_mem     out  1   freeze request to the stall controller
//  addr_err         out  1   one-cycle pulse: completed access was out of range
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state = IDLE; cnt = 0; rdata = 0; rvalid = 0; addr_err = 0.
//   - Latched request is discarded; a pending store is dropped and never written.
//   - Memory contents are not reset.
//  Decode:
//   - off = addr - BASE_ADDR (64-bit, wraps).
//   - In range iff off[63:ADDR_W+3] == 0; word index = off[ADDR_W+2:3].
//  FSM states: IDLE, WAIT.
//   - IDLE, en=0: nothing happens; stallreq = 0.
//   - IDLE, en=1, WAIT_CYC=0: access completes at this edge; stay IDLE; stallreq = 0.
//   - IDLE, en=1, WAIT_CYC>0:
//     - Latch {we, word index, range flag, wdata}; cnt <= WAIT_CYC-1; go to WAIT.
//     - stallreq = 1 combinationally in this cycle.
//   - WAIT, cnt != 0: cnt decrements; stallreq = 1.
//   - WAIT, cnt == 0: stallreq = 0; latched access completes at this edge; go to IDLE.
//   - Total stallreq-high cycles per access = WAIT_CYC exactly.
//   - en is ignored in WAIT. EX holds the same request while stalled; it must not be re-accepted.
//  Completion at edge E:
//   - Store, in range: mem[idx] byte lanes with we[i]=1 get wdata[8i+7:8i]; other lanes unchanged.
//   - Load, in range: rdata <= mem[idx]; rvalid = 1 in cycle after E.
//   - Out of range: no memory write; load rdata <= 0 and rvalid = 1; addr_err = 1 in cycle after E.
//   - rdata holds its value until the next completed load. rvalid and addr_err are 0 otherwise.
//  Latency (edge to rdata/rvalid):
//   - WAIT_CYC=0: load at cycle T -> rdata/rvalid at T+1.
//   - WAIT_CYC=N: load at cycle T -> rdata/rvalid at T+N+1.
//  Simultaneous events and ordering:
//   - Back-to-back accesses with WAIT_CYC=0 complete one per cycle, in order.
//   - A load at T+1 after a store to the same word at T returns the stored data.
//   - rst has priority over every other event.
// TESTING
//  1. WAIT_CYC=0:
//     - Store we=FF addr=BASE+8 wdata=1122334455667788; next cycle load addr=BASE+8.
//     - Expect rdata=1122334455667788 with rvalid at load cycle+1; stallreq stays 0.
//  2. Byte merge:
//     - Word at BASE holds 0; store we=0x0C wdata=0000_0000_AABB_0000.
//     - Load BASE -> rdata=0000_0000_AABB_0000.
//  3. WAIT_CYC=3, load at cycle T:
//     - stallreq high at T,T+1,T+2 and low at T+3.
//     - rvalid at T+4; en held high during stall causes no second access.
//  4. Out of range: load addr=BASE+(2**ADDR_W)*8 -> rdata=0, rvalid=1, addr_err=1 next cycle.
//  5. Store to BASE-8 -> addr_err=1; a reload of BASE+(2**ADDR_W-1)*8 shows it unchanged.
//  6. Reset mid-WAIT:
//     - WAIT_CYC=5; store to BASE; assert rst at T+2.
//     - Expect stallreq=0 after the reset edge, state IDLE, and the word at BASE unchanged.
//  7. Back-to-back, WAIT_CYC=0: stores to BASE, BASE+8, BASE+16, then three loads -> data returned in order.

Source files
------------

// File: rtl/dsram_resp.sv
// Responder for the EX-stage data SRAM port: 64-bit, byte-writable memory,
// one access at a time, registered load data, and optional wait states that
// hold a stall request while an access is pending.
module dsram_resp #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [63:0] BASE_ADDR = 64'h80000000,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        stallreq_mem,
  output logic        addr_err
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam bit          HAS_WAIT = (WAIT_CYC != 0);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYC - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [7:0]          lat_we_q;
  logic [ADDR_W-1:0]   lat_idx_q;
  logic                lat_inr_q;
  logic [63:0]         lat_wdata_q;

  logic [63:0]         mem [DEPTH];

  logic [63:0]         rdata_q;
  logic                rvalid_q;
  logic                addr_err_q;

  // Address decode of the live request
  logic [63:0]         off;
  logic                req_inr;
  logic [ADDR_W-1:0]   req_idx;
  logic                unused_off_lsbs;

  assign off             = data_sram_addr - BASE_ADDR;
  assign req_inr         = (off[63:ADDR_W+3] == '0);
  assign req_idx         = off[ADDR_W+2:3];
  assign unused_off_lsbs = ^off[2:0];

  // Completion interface: the access retiring at the coming edge
  logic                cmp_valid;
  logic [7:0]          cmp_we;
  logic [ADDR_W-1:0]   cmp_idx;
  logic                cmp_inr;
  logic [63:0]         cmp_wdata;
  logic                accept;
  logic                cmp_load;

  assign accept   = (state_q == S_IDLE) && data_sram_en && HAS_WAIT;
  assign cmp_load = cmp_valid && (cmp_we == '0);

  // State, wait counter and latched request; reset drops any pending access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_we_q    <= '0;
      lat_idx_q   <= '0;
      lat_inr_q   <= 1'b0;
      lat_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_we_q    <= data_sram_we;
        lat_idx_q   <= req_idx;
        lat_inr_q   <= req_inr;
        lat_wdata_q <= data_sram_wdata;
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (data_sram_en && HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall request and selection of the completing access
  always_comb begin
    stallreq_mem = 1'b0;
    cmp_valid    = 1'b0;
    cmp_we       = data_sram_we;
    cmp_idx      = req_idx;
    cmp_inr      = req_inr;
    cmp_wdata    = data_sram_wdata;
    unique case (state_q)
      S_IDLE: begin
        stallreq_mem = data_sram_en && HAS_WAIT;
        cmp_valid    = data_sram_en && !HAS_WAIT;
      end
      S_WAIT: begin
        stallreq_mem = (cnt_q != '0);
        cmp_valid    = (cnt_q == '0);
        cmp_we       = lat_we_q;
        cmp_idx      = lat_idx_q;
        cmp_inr      = lat_inr_q;
        cmp_wdata    = lat_wdata_q;
      end
      default: ;
    endcase
  end

  // Byte-lane memory write; suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && cmp_valid && cmp_inr) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (cmp_we[i]) mem[cmp_idx][8*i +: 8] <= cmp_wdata[8*i +: 8];
      end
    end
  end

  // Registered load response and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_q   <= cmp_load;
      addr_err_q <= cmp_valid && !cmp_inr;
      if (cmp_load) rdata_q <= cmp_inr ? mem[cmp_idx] : '0;
    end
  end

  assign data_sram_rdata  = rdata_q;
  assign data_sram_rvalid = rvalid_q;
  assign addr_err         = addr_err_q;

endmodule
